axis_loopback_fifo: RTL and testbench

- AXI4-Stream store-and-forward FIFO for the example streaming chip.
- Sits between an upstream stream master, which connects to the s_axis port, and a downstream stream slave, which connects to the m_axis port.
- Every accepted beat is forwarded unmodified, in order, with no loss or duplication, regardless of downstream back-pressure.

---
 rtl/axis_loopback_pkg.sv | 13 +
 rtl/axis_fifo_ram.sv | 28 ++
 rtl/axis_loopback_fifo.sv | 101 ++++++++++
 tb/tb_axis_loopback_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_loopback_pkg.sv
// Shared defaults and beat layout for the AXI4-Stream loopback FIFO.
package axis_loopback_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;

    typedef struct packed {
        logic                      tlast;
        logic [DATA_W_DEF/8-1:0]   tkeep;
        logic [DATA_W_DEF-1:0]     tdata;
    } axis_beat_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, asynchronous read so the
// head entry is visible the cycle after it is written.
module axis_fifo_ram
    import axis_loopback_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = $bits(axis_beat_t),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array: contents are meaningless until written.
    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_loopback_fifo.sv
// AXI4-Stream store-and-forward FIFO, first-word-fall-through, with occupancy.
// Ready/valid are derived from the registered count only (plus reset gating).
module axis_loopback_fifo
    import axis_loopback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic [DATA_W/8-1:0]      s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [DATA_W/8-1:0]      m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int KW = DATA_W / 8;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic              tlast;
        logic [KW-1:0]     tkeep;
        logic [DATA_W-1:0] tdata;
    } beat_t;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    beat_t         wr_beat, rd_beat;

    // Full blocks input even when a pop is in flight: no same-cycle pass-through.
    assign s_axis_tready = !areset && (count != FULL);
    assign m_axis_tvalid = !areset && (count != '0);

    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    assign wr_beat = '{tlast: s_axis_tlast, tkeep: s_axis_tkeep, tdata: s_axis_tdata};

    axis_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr),
        .rd_data (rd_beat)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign m_axis_tdata = rd_beat.tdata;
    assign m_axis_tkeep = rd_beat.tkeep;
    assign m_axis_tlast = rd_beat.tlast;
    assign occupancy    = count;

`ifndef SYNTHESIS
    // Underflow wraps count past DEPTH, so one bound check covers both directions.
    logic  stall_q;
    beat_t held_q;

    always_ff @(posedge aclk) begin
        stall_q <= !areset && m_axis_tvalid && !m_axis_tready;
        held_q  <= rd_beat;
        if (!areset) begin
            assert (count <= FULL)
                else $error("count out of range: %0d", count);
            if (stall_q)
                assert (rd_beat == held_q)
                    else $error("m_axis outputs changed while stalled");
        end
    end
`endif

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// Directed bench for axis_loopback_fifo with a queue scoreboard and per-cycle handshake model.
module tb_axis_loopback_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic [3:0]    s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [3:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [4:0]    occupancy;

    always #5 aclk = ~aclk;

    axis_loopback_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .occupancy     (occupancy)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    n_push = 0;
    int    n_pop = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic  exp_rdy, exp_vld, do_push, do_pop, rst;
        beat_t cur, inb;
        @(negedge aclk);
        rst     = areset;
        exp_rdy = !rst && (sb.size() != DEPTH);
        exp_vld = !rst && (sb.size() != 0);
        chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
        chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_vld));
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        cur = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (exp_vld) begin
            chk("m_tdata", 64'(cur.d), 64'(sb[0].d));
            chk("m_tkeep", 64'(cur.k), 64'(sb[0].k));
            chk("m_tlast", 64'(cur.l), 64'(sb[0].l));
        end
        if (prev_stall && exp_vld) begin
            chk("stall_tdata", 64'(cur.d), 64'(prev_out.d));
            chk("stall_tkeep", 64'(cur.k), 64'(prev_out.k));
            chk("stall_tlast", 64'(cur.l), 64'(prev_out.l));
        end
        prev_stall = exp_vld && !m_axis_tready;
        prev_out   = cur;
        do_push    = exp_rdy && s_axis_tvalid;
        do_pop     = exp_vld && m_axis_tready;
        inb        = '{s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        @(posedge aclk);
        if (rst) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
                n_pop++;
            end
            if (do_push) begin
                sb.push_back(inb);
                n_push++;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
    endtask

    initial begin
        int base, sent, p;
        areset = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        @(posedge aclk); #1;

        // Reset state: still in reset, count already cleared
        tick();
        areset = 1'b0;
        tick();

        // Single beat
        m_axis_tready = 1'b1;
        drive(32'hDEADBEEF, 4'hF, 1'b1);
        tick();
        s_axis_tvalid = 1'b0;
        chk("single_vld", 64'(m_axis_tvalid), 64'd1);
        chk("single_data", 64'(m_axis_tdata), 64'hDEADBEEF);
        chk("single_last", 64'(m_axis_tlast), 64'd1);
        tick();
        chk("single_occ", 64'(occupancy), 64'd0);

        // Nine random beats with downstream ready 2 low / 6 high
        base = n_pop; sent = 0;
        drive($urandom, 4'($urandom_range(15)), 1'b0);
        for (int c = 0; c < 200 && (n_pop - base) < 9; c++) begin
            m_axis_tready = (c % 8) >= 2;
            s_axis_tvalid = (sent < 9);
            p = n_push;
            tick();
            if (n_push != p) begin
                sent++;
                s_axis_tdata = $urandom;
                s_axis_tkeep = 4'($urandom_range(15));
                s_axis_tlast = (sent == 8);
            end
        end
        s_axis_tvalid = 1'b0;
        chk("rand_popped", 64'(n_pop - base), 64'd9);

        // Fill against a stalled sink
        m_axis_tready = 1'b0;
        base = n_push;
        for (int i = 0; i < 20; i++) begin
            drive(32'h1000_0000 + 32'(n_push - base), 4'hF, 1'b0);
            tick();
        end
        s_axis_tvalid = 1'b0;
        chk("fill_count", 64'(n_push - base), 64'd16);
        chk("fill_tready", 64'(s_axis_tready), 64'd0);
        chk("fill_occ", 64'(occupancy), 64'd16);
        chk("fill_head", 64'(m_axis_tdata), 64'h1000_0000);
        m_axis_tready = 1'b1;
        tick();
        chk("after_pop_tready", 64'(s_axis_tready), 64'd1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("fill_drained", 64'(occupancy), 64'd0);

        // Steady state at occupancy 5
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(32'h2000_0000 + 32'(i), 4'h3, 1'(i & 1));
            tick();
        end
        chk("steady_fill", 64'(occupancy), 64'd5);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(32'h2000_0005 + 32'(i), 4'h3, 1'(i & 1));
            tick();
            chk("steady_occ", 64'(occupancy), 64'd5);
        end
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();

        // Reset mid-stream
        m_axis_tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(32'h3000_0000 + 32'(i), 4'hF, 1'b0);
            tick();
        end
        chk("mid_occ", 64'(occupancy), 64'd7);
        areset = 1'b1;
        drive(32'hBAD0_0000, 4'hF, 1'b1);
        tick();
        chk("rst_occ", 64'(occupancy), 64'd0);
        areset = 1'b0;
        drive(32'h0000_0001, 4'hF, 1'b0);
        tick();
        s_axis_tvalid = 1'b0;
        chk("rst_next_vld", 64'(m_axis_tvalid), 64'd1);
        chk("rst_next_data", 64'(m_axis_tdata), 64'h1);
        m_axis_tready = 1'b1;
        tick();

        // Empty read
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("empty_vld", 64'(m_axis_tvalid), 64'd0);
            chk("empty_occ", 64'(occupancy), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
